// File: rtl/bcd_conv_sequencer.sv
// ---------------------------------------------------------------------------
// bcd_conv_sequencer
// Shares one start/done-less iterative binary-to-BCD converter among N_REQ
// requesters. A round-robin arbiter picks a requester. Its operand is then
// driven onto the converter and held for CONV_CYCLES clocks. The settled
// result is captured and handed back with a one-cycle done pulse.
//
// Ports
//   clk       in   1            system clock, rising edge
//   rst_n     in   1            asynchronous active-low reset
//   req       in   N_REQ        per-requester request level
//   bin       in   N_REQ*B_W    packed operands, requester i at [i*B_W +: B_W]
//   gnt       out  N_REQ        one-hot grant, held for the whole conversion
//   done      out  N_REQ        one-hot, one-cycle result-valid pulse
//   bcd_out   out  BCD_W        last captured result
//   busy      out  1            conversion in progress
//   conv_b    out  B_W          converter operand input
//   conv_bcd  in   BCD_W        converter result output
// ---------------------------------------------------------------------------
module bcd_conv_sequencer #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned B_W         = 12,
    parameter int unsigned BCD_W       = 16,
    parameter int unsigned CONV_CYCLES = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*B_W-1:0]   bin,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic [BCD_W-1:0]       bcd_out,
    output logic                   busy,
    output logic [B_W-1:0]         conv_b,
    input  logic [BCD_W-1:0]       conv_bcd
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   r_done;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_busy;
    logic [B_W-1:0]     r_conv_b;
    logic [IDX_W-1:0]   r_last;
    logic [CNT_W-1:0]   r_cnt;

    logic [N_REQ-1:0]   w_gnt_nxt;
    logic [N_REQ-1:0]   w_done_nxt;
    logic [BCD_W-1:0]   w_bcd_nxt;
    logic               w_busy_nxt;
    logic [B_W-1:0]     w_conv_b_nxt;
    logic [IDX_W-1:0]   w_last_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    logic               w_win_vld;
    logic [IDX_W-1:0]   w_win_idx;
    logic [IDX_W-1:0]   w_cand;
    int                 w_cand_i;
    logic [B_W-1:0]     w_bin_arr [N_REQ];

    // Unpack operand bus into a per-requester array
    for (genvar gi = 0; gi < int'(N_REQ); gi++) begin : g_bin
        assign w_bin_arr[gi] = bin[gi*B_W +: B_W];
    end

    // Round-robin winner: first requesting index after r_last, wrapping
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = '0;
        w_cand    = '0;
        w_cand_i  = 0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            w_cand_i = int'(r_last) + k;
            if (w_cand_i >= int'(N_REQ)) begin
                w_cand_i = w_cand_i - int'(N_REQ);
            end
            w_cand = IDX_W'(w_cand_i);
            if (!w_win_vld && req[w_cand]) begin
                w_win_vld = 1'b1;
                w_win_idx = w_cand;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. WAIT hands over to CAPTURE on the edge where cnt
    // reaches zero, so the capture edge lands exactly CONV_CYCLES edges after
    // the grant edge.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_win_vld) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output / datapath next values
    always_comb begin
        w_gnt_nxt    = r_gnt;
        w_done_nxt   = '0;
        w_bcd_nxt    = r_bcd;
        w_busy_nxt   = r_busy;
        w_conv_b_nxt = r_conv_b;
        w_last_nxt   = r_last;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_win_vld) begin
                    w_gnt_nxt    = N_REQ'(1) << w_win_idx;
                    w_conv_b_nxt = w_bin_arr[w_win_idx];
                    w_last_nxt   = w_win_idx;
                    w_cnt_nxt    = CNT_W'(CONV_CYCLES - 1);
                    w_busy_nxt   = 1'b1;
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
            end
            S_CAPTURE: begin
                w_bcd_nxt  = conv_bcd;
                w_done_nxt = r_gnt;
                w_gnt_nxt  = '0;
                w_busy_nxt = 1'b0;
            end
            default: begin
                w_gnt_nxt  = '0;
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // Datapath / output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt    <= '0;
            r_done   <= '0;
            r_bcd    <= '0;
            r_busy   <= 1'b0;
            r_conv_b <= '0;
            r_last   <= IDX_W'(N_REQ - 1);
            r_cnt    <= '0;
        end else begin
            r_gnt    <= w_gnt_nxt;
            r_done   <= w_done_nxt;
            r_bcd    <= w_bcd_nxt;
            r_busy   <= w_busy_nxt;
            r_conv_b <= w_conv_b_nxt;
            r_last   <= w_last_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign bcd_out = r_bcd;
    assign busy    = r_busy;
    assign conv_b  = r_conv_b;

endmodule

// File: tb/tb_bcd_conv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bcd_conv_sequencer
// Directed bench for bcd_conv_sequencer with a behavioural converter that
// only yields the right BCD once its input has been stable long enough.
// ---------------------------------------------------------------------------
module tb_bcd_conv_sequencer;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned B_W   = 12;
    localparam int unsigned BCD_W = 16;
    localparam int unsigned CC    = 24;

    logic                   clk;
    logic                   rst_n;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*B_W-1:0]   bin;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       done;
    logic [BCD_W-1:0]       bcd_out;
    logic                   busy;
    logic [B_W-1:0]         conv_b;
    logic [BCD_W-1:0]       conv_bcd;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int bad_inv  = 0;
    int bad_dead = 0;

    int             g_idx [$];
    int             g_cyc [$];
    int             d_idx [$];
    int             d_cyc [$];
    logic [15:0]    d_val [$];
    logic [N_REQ-1:0] prev_gnt = '0;

    bcd_conv_sequencer #(
        .N_REQ(N_REQ), .B_W(B_W), .BCD_W(BCD_W), .CONV_CYCLES(CC)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .bin(bin), .gnt(gnt),
        .done(done), .bcd_out(bcd_out), .busy(busy), .conv_b(conv_b),
        .conv_bcd(conv_bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [15:0] to_bcd(input int v);
        logic [3:0] d3, d2, d1, d0;
        d3 = 4'(v / 1000);
        d2 = 4'((v / 100) % 10);
        d1 = 4'((v / 10) % 10);
        d0 = 4'(v % 10);
        return {d3, d2, d1, d0};
    endfunction

    function automatic int oh_idx(input logic [N_REQ-1:0] v);
        for (int i = 0; i < int'(N_REQ); i++) if (v[i]) return i;
        return -1;
    endfunction

    // Converter model: m_stab counts whole cycles elapsed since conv_b last
    // changed; the cycle in progress completes at the next edge, so the
    // result is valid for sampling once m_stab >= CC-1.
    logic [B_W-1:0] m_prev = '0;
    int             m_stab = 0;
    always @(posedge clk) begin
        if (conv_b !== m_prev) begin
            m_prev <= conv_b;
            m_stab <= 1;
        end else if (m_stab < int'(CC)) begin
            m_stab <= m_stab + 1;
        end
    end
    assign conv_bcd = (m_stab >= int'(CC) - 1) ? to_bcd(int'(m_prev)) : 16'hDEAD;

    // Event log and invariant watch, sampled on the falling edge
    always @(negedge clk) begin
        if (gnt != '0 && prev_gnt == '0) begin
            g_idx.push_back(oh_idx(gnt));
            g_cyc.push_back(cyc);
        end
        if (done != '0) begin
            d_idx.push_back(oh_idx(done));
            d_cyc.push_back(cyc);
            d_val.push_back(bcd_out);
            if (bcd_out == 16'hDEAD) bad_dead++;
        end
        if (!$onehot0(gnt) || !$onehot0(done) || (done != '0 && gnt != '0)) bad_inv++;
        prev_gnt = gnt;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_log();
        g_idx.delete(); g_cyc.delete();
        d_idx.delete(); d_cyc.delete(); d_val.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        #1;
        clr_log();
        rst_n = 1'b1;
    endtask

    task automatic set_bin(input int i, input int v);
        bin[i*B_W +: B_W] = B_W'(v);
    endtask

    // Wait for n logged dones; optionally drop req of each finished requester
    task automatic wait_dones(input int n, input bit drop, input string tag);
        int b;
        b = 0;
        while (d_idx.size() < n && b < 400) begin
            @(negedge clk); #1;
            if (drop) req = req & ~done;
            b++;
        end
        chk(tag, 32'(d_idx.size() >= n), 32'd1);
    endtask

    task automatic wait_grants(input int n, input string tag);
        int b;
        b = 0;
        while (g_idx.size() < n && b < 100) begin
            @(negedge clk); #1;
            b++;
        end
        chk(tag, 32'(g_idx.size() >= n), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        bin   = '0;
        #12;
        // Reset state
        chk("rst_gnt",  32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bcd",  32'(bcd_out), 32'd0);
        chk("rst_convb", 32'(conv_b), 32'd0);

        // 1: single request
        do_reset();
        set_bin(0, 3456);
        req = 4'b0001;
        wait_grants(1, "t1_wait_gnt");
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_convb", 32'(conv_b), 32'd3456);
        wait_dones(1, 1'b1, "t1_wait_done");
        if (d_idx.size() >= 1 && g_idx.size() >= 1) begin
            chk("t1_lat", 32'(d_cyc[0] - g_cyc[0]), 32'(CC));
            chk("t1_bcd", 32'(d_val[0]), 32'h3456);
            chk("t1_done", 32'(d_idx[0]), 32'd0);
        end
        @(negedge clk); #1;
        chk("t1_done_pulse", 32'(done), 32'd0);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // 2: all four at once
        do_reset();
        set_bin(0, 999); set_bin(1, 75); set_bin(2, 8); set_bin(3, 4095);
        req = 4'b1111;
        wait_dones(4, 1'b1, "t2_wait_done");
        if (d_idx.size() >= 4 && g_idx.size() >= 4) begin
            chk("t2_g0", 32'(g_idx[0]), 32'd0);
            chk("t2_g1", 32'(g_idx[1]), 32'd1);
            chk("t2_g2", 32'(g_idx[2]), 32'd2);
            chk("t2_g3", 32'(g_idx[3]), 32'd3);
            chk("t2_r0", 32'(d_val[0]), 32'h0999);
            chk("t2_r1", 32'(d_val[1]), 32'h0075);
            chk("t2_r2", 32'(d_val[2]), 32'h0008);
            chk("t2_r3", 32'(d_val[3]), 32'h4095);
            for (int i = 1; i < 4; i++)
                chk("t2_gap", 32'(d_cyc[i] - d_cyc[i-1]), 32'(CC + 1));
        end

        // 3: fairness between 0 and 2
        do_reset();
        set_bin(0, 11); set_bin(2, 22);
        req = 4'b0101;
        wait_dones(4, 1'b0, "t3_wait_done");
        req = '0;
        if (g_idx.size() >= 4) begin
            chk("t3_g0", 32'(g_idx[0]), 32'd0);
            chk("t3_g1", 32'(g_idx[1]), 32'd2);
            chk("t3_g2", 32'(g_idx[2]), 32'd0);
            chk("t3_g3", 32'(g_idx[3]), 32'd2);
            chk("t3_r1", 32'(d_val[1]), 32'h0022);
        end

        // 4: churn on operand and request during WAIT
        do_reset();
        set_bin(0, 100);
        req = 4'b0001;
        wait_grants(1, "t4_wait_gnt");
        repeat (8) @(negedge clk);
        #1;
        set_bin(0, 777);
        req = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("t4_convb", 32'(conv_b), 32'd100);
        chk("t4_busy", 32'(busy), 32'd1);
        wait_dones(1, 1'b0, "t4_wait_done");
        if (d_idx.size() >= 1) begin
            chk("t4_bcd", 32'(d_val[0]), 32'h0100);
            chk("t4_done", 32'(d_idx[0]), 32'd0);
        end

        // 5: reset mid-WAIT (no reset before, so bcd_out holds 0x0100)
        clr_log();
        set_bin(0, 500);
        req = 4'b0001;
        wait_grants(1, "t5_wait_gnt");
        repeat (13) @(negedge clk);
        #1;
        rst_n = 1'b0;
        clr_log();
        #1;
        chk("t5_gnt",  32'(gnt), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_bcd",  32'(bcd_out), 32'd0);
        chk("t5_convb", 32'(conv_b), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        req = 4'b0110;
        set_bin(1, 42); set_bin(2, 43);
        repeat (2) @(negedge clk);
        #1;
        chk("t5_no_done", 32'(d_idx.size()), 32'd0);
        rst_n = 1'b1;
        wait_dones(1, 1'b1, "t5_wait_done");
        if (g_idx.size() >= 1 && d_idx.size() >= 1) begin
            chk("t5_first", 32'(g_idx[0]), 32'd1);
            chk("t5_bcd1", 32'(d_val[0]), 32'h0042);
        end

        // 6: back-to-back on requester 3
        do_reset();
        set_bin(3, 1234);
        req = 4'b1000;
        wait_dones(2, 1'b0, "t6_wait_done");
        req = '0;
        if (g_idx.size() >= 2 && d_idx.size() >= 2) begin
            chk("t6_g0", 32'(g_idx[0]), 32'd3);
            chk("t6_g1", 32'(g_idx[1]), 32'd3);
            chk("t6_regnt", 32'(g_cyc[1] - d_cyc[0]), 32'd1);
            chk("t6_r0", 32'(d_val[0]), 32'h1234);
            chk("t6_r1", 32'(d_val[1]), 32'h1234);
        end

        chk("inv_onehot", 32'(bad_inv), 32'd0);
        chk("no_dead", 32'(bad_dead), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
